msix_irq_scheduler: RTL and testbench
=====================================

// Module: msix_irq_scheduler
// PURPOSE
//  Sequences MSI-X delivery between the user irq inputs and the PCIe core cfg_interrupt_msix_* handshake.
//  Latches irq pulses into a pending array (PBA image) and round-robin arbitrates among pending vectors.
//  For each granted vector, reads its entry from the MSI-X table RAM through a 1-cycle-latency read port.
//  Issues the interrupt to the core, then handles sent/fail with bounded retry.
// PARAMETERS
//  C_NUM_IRQ_INPUTS     4      number of vectors/irq inputs (1..32)
//  C_TABLE_ADDR_WIDTH   9      byte-address width of the table read port
//  C_MSIX_TABLE_OFFSET  0      byte offset of entry 0; entry i at offset+16*i
//  C_MAX_RETRIES        3      consecutive fails on one vector before the vector is dropped (>=1)
// PORTS
//  clk                         in   1    clock
//  rst                         in   1    synchronous reset, active-high
//  irq                         in   N    per-vector request; any cycle high sets pending[i]
//  msix_enable                 in   1    function MSI-X enable (cfg_interrupt_msix_enable[0])
//  msix_func_mask              in   1    function mask (cfg_interrupt_msix_mask[0])
//  tbl_raddr                   out  AW   table read byte address
//  tbl_rdata                   in   32   table read data, valid the cycle after tbl_raddr
//  cfg_interrupt_msix_int      out  1    one-cycle request pulse to core
//  cfg_interrupt_msix_address  out  64   message address {hi,lo}
//  cfg_interrupt_msix_data     out  32   message data
//  cfg_interrupt_msix_sent     in   1    core: message sent (one-cycle pulse)
//  cfg_interrupt_msix_fail     in   1    core: message failed (one-cycle pulse)
//  pending                     out  N    pending bit array
//  busy                        out  1    high in any state except IDLE
//  drop                        out  1    one-cycle pulse when a vector is dropped after retries
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pending=0; rr_ptr=0; fail_cnt=0. A reset in any state aborts immediately.
//  Entry layout: +0 addr_lo, +4 addr_hi, +8 data, +C vector control (bit0=mask).
//  Arbitration:
//   - grant = first set pending bit searching upward from rr_ptr, with wrap.
//   - After each grant, rr_ptr = (grant+1) mod N, whether the vector is issued or skipped.
//  FSM (each read state drives tbl_raddr; its data is captured in the next state):
//   IDLE  - If msix_enable & ~msix_func_mask & |pending: latch grant, drive +C, go CHK.
//   CHK   - Capture ctrl.
//           mask=1 -> IDLE; pending bit kept.
//           mask=0 -> drive +0, go LO.
//   LO    - Capture addr_lo; drive +4; go HI.
//   HI    - Capture addr_hi; drive +8; go DAT.
//   DAT   - Capture data; go ISSUE.
//   ISSUE - cfg_interrupt_msix_int=1 for exactly this cycle; clear pending[grant]; go WAIT.
//   WAIT  - Hold address/data stable until sent or fail.
//           sent -> fail_cnt=0; go IDLE.
//           fail -> fail_cnt+1.
//             If fail_cnt+1 < C_MAX_RETRIES: re-set pending[grant].
//             Else: pulse drop, leave pending clear, fail_cnt=0.
//           Go IDLE in both fail cases.
//  fail_cnt also clears when a different vector is granted.
//  Latency: irq high in cycle T -> pending set at T+1 -> cfg_interrupt_msix_int high at T+6 (idle, unmasked).
//  Simultaneous events:
//   - irq[grant] in the ISSUE cycle: set wins, vector stays pending.
//   - sent and fail in the same cycle: treat as sent.
//  Enable or function mask deasserting:
//   - In CHK/LO/HI/DAT: abort to IDLE, pending kept.
//   - In WAIT: ignored until the handshake completes.
//   - While deasserted: no grant; pending keeps accumulating.
//  cfg_interrupt_msix_address/data reset to 0, update only in LO/HI/DAT, never change during WAIT.
// TESTING
//  1. Table entries i=0..3: lo=0xFFF0+i, hi=i, data=0xCAFE+(i<<16); one-cycle irq=4'b1101.
//     -> Ints for vectors 0,2,3 in that order.
//     -> Vector 2 carries address 0x00000002_0000FFF2 and data 0x0002CAFE.
//     -> First int at T+6; each subsequent int follows its sent pulse.
//  2. Ctrl of vector 2 = 1; irq=4'b0100 -> no int for 200 cycles, pending=4'b0100.
//     Then ctrl of vector 2 = 0 -> one int with data 0x0002CAFE, pending=0.
//  3. Core answers fail, fail, sent -> three ints on the same vector, drop never pulses.
//     Core answers fail x3 -> drop pulses once, pending bit 0, no fourth int.
//  4. irq[0] held high, irq[1] pulsed once -> grant order 0,1,0,0...; vector 1 served within 2 grants.
//  5. msix_enable=0, irq=4'b0011 -> no int, pending=4'b0011.
//     Then msix_enable=1 -> ints for vectors 0 then 1.
//  6. rst=1 during WAIT -> next cycle int=0, pending=0, busy=0.
//     A following irq=4'b0001 is served normally with int at T+6.

Source files
------------

// File: rtl/msix_irq_scheduler.sv
// MSI-X delivery sequencer: latches irq pulses into a pending array, round-robin
// arbitrates, fetches the table entry and runs the cfg_interrupt_msix handshake with bounded retry.
module msix_irq_scheduler #(
  parameter int C_NUM_IRQ_INPUTS    = 4,
  parameter int C_TABLE_ADDR_WIDTH  = 9,
  parameter int C_MSIX_TABLE_OFFSET = 0,
  parameter int C_MAX_RETRIES       = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_NUM_IRQ_INPUTS-1:0]   irq,
  input  logic                          msix_enable,
  input  logic                          msix_func_mask,
  output logic [C_TABLE_ADDR_WIDTH-1:0] tbl_raddr,
  input  logic [31:0]                   tbl_rdata,
  output logic                          cfg_interrupt_msix_int,
  output logic [63:0]                   cfg_interrupt_msix_address,
  output logic [31:0]                   cfg_interrupt_msix_data,
  input  logic                          cfg_interrupt_msix_sent,
  input  logic                          cfg_interrupt_msix_fail,
  output logic [C_NUM_IRQ_INPUTS-1:0]   pending,
  output logic                          busy,
  output logic                          drop
);

  // state | meaning
  // IDLE  | wait for an enabled, unmasked function with pending work; read ctrl word
  // CHK   | check vector mask bit; read addr_lo
  // LO    | capture addr_lo; read addr_hi
  // HI    | capture addr_hi; read data
  // DAT   | capture data
  // ISSUE | int pulse to core, pending bit cleared
  // WAIT  | hold message until sent/fail
  typedef enum logic [2:0] {S_IDLE, S_CHK, S_LO, S_HI, S_DAT, S_ISSUE, S_WAIT} state_t;

  localparam int N  = C_NUM_IRQ_INPUTS;
  localparam int AW = C_TABLE_ADDR_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(C_MAX_RETRIES + 1);

  state_t          state_q;
  logic [PW-1:0]   grant_q, rr_q, last_q;
  logic [CW-1:0]   fail_cnt_q;
  logic [N-1:0]    pending_q, pending_d, pend_set, pend_clr;
  logic            int_q, drop_q;
  logic [63:0]     addr_q;
  logic [31:0]     data_q;
  logic [PW-1:0]   grant_c;
  logic            found_c, ok_c, go_c, retry_c;
  int              idx_c;

  function automatic logic [AW-1:0] ent_addr(input logic [PW-1:0] v, input int off);
    return AW'(C_MSIX_TABLE_OFFSET + 16 * int'(v) + off);
  endfunction

  // first pending vector at or above rr_q, wrapping
  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    idx_c   = 0;
    for (int k = 0; k < N; k++) begin
      idx_c = int'(rr_q) + k;
      if (idx_c >= N) idx_c = idx_c - N;
      if (!found_c && pending_q[idx_c]) begin
        found_c = 1'b1;
        grant_c = PW'(idx_c);
      end
    end
  end

  assign ok_c    = msix_enable & ~msix_func_mask;
  assign go_c    = ok_c & found_c;
  assign retry_c = (int'(fail_cnt_q) + 1) < C_MAX_RETRIES;

  always_comb begin
    tbl_raddr = '0;
    case (state_q)
      S_IDLE:  if (go_c) tbl_raddr = ent_addr(grant_c, 12);
      S_CHK:   tbl_raddr = ent_addr(grant_q, 0);
      S_LO:    tbl_raddr = ent_addr(grant_q, 4);
      S_HI:    tbl_raddr = ent_addr(grant_q, 8);
      default: tbl_raddr = '0;
    endcase
  end

  // a new irq in the ISSUE cycle wins over the clear
  always_comb begin
    pend_set = irq;
    pend_clr = '0;
    if (state_q == S_ISSUE) pend_clr[grant_q] = 1'b1;
    if (state_q == S_WAIT && cfg_interrupt_msix_fail && !cfg_interrupt_msix_sent && retry_c)
      pend_set[grant_q] = 1'b1;
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      last_q     <= '0;
      fail_cnt_q <= '0;
      pending_q  <= '0;
      int_q      <= 1'b0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      pending_q <= pending_d;
      int_q     <= 1'b0;
      drop_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (go_c) begin
          grant_q <= grant_c;
          rr_q    <= (int'(grant_c) == N - 1) ? '0 : grant_c + 1'b1;
          last_q  <= grant_c;
          if (grant_c != last_q) fail_cnt_q <= '0;
          state_q <= S_CHK;
        end
        S_CHK:   state_q <= (!ok_c || tbl_rdata[0]) ? S_IDLE : S_LO;
        S_LO: if (!ok_c) state_q <= S_IDLE;
          else begin
            addr_q[31:0] <= tbl_rdata;
            state_q      <= S_HI;
          end
        S_HI: if (!ok_c) state_q <= S_IDLE;
          else begin
            addr_q[63:32] <= tbl_rdata;
            state_q       <= S_DAT;
          end
        S_DAT: if (!ok_c) state_q <= S_IDLE;
          else begin
            data_q  <= tbl_rdata;
            int_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: if (cfg_interrupt_msix_sent) begin
            fail_cnt_q <= '0;
            state_q    <= S_IDLE;
          end else if (cfg_interrupt_msix_fail) begin
            if (retry_c) fail_cnt_q <= fail_cnt_q + 1'b1;
            else begin
              drop_q     <= 1'b1;
              fail_cnt_q <= '0;
            end
            state_q <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_interrupt_msix_int     = int_q;
  assign cfg_interrupt_msix_address = addr_q;
  assign cfg_interrupt_msix_data    = data_q;
  assign pending                    = pending_q;
  assign busy                       = (state_q != S_IDLE);
  assign drop                       = drop_q;

endmodule

// File: tb/tb_msix_irq_scheduler.sv
// Scoreboard bench for msix_irq_scheduler: table RAM and core responder models,
// expected messages queued at stimulus time and popped on each int pulse.
module tb_msix_irq_scheduler;

  logic        clk = 1'b0;
  logic        rst, msix_enable, msix_func_mask;
  logic [3:0]  irq;
  logic [8:0]  tbl_raddr;
  logic [31:0] tbl_rdata = '0;
  logic        cfg_int, sent, fail;
  logic [63:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [3:0]  pending;
  logic        busy, drop;

  msix_irq_scheduler #(
    .C_NUM_IRQ_INPUTS(4), .C_TABLE_ADDR_WIDTH(9),
    .C_MSIX_TABLE_OFFSET(0), .C_MAX_RETRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq),
    .msix_enable(msix_enable), .msix_func_mask(msix_func_mask),
    .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .cfg_interrupt_msix_int(cfg_int),
    .cfg_interrupt_msix_address(cfg_addr),
    .cfg_interrupt_msix_data(cfg_data),
    .cfg_interrupt_msix_sent(sent), .cfg_interrupt_msix_fail(fail),
    .pending(pending), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:127];
  always @(posedge clk) tbl_rdata <= mem[tbl_raddr[8:2]];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   resp_q[$];   // 0 = sent, 1 = fail, 2 = never answer
  int   int_cyc_q[$];
  int   int_cnt = 0, drop_cnt = 0;
  exp_t mon_e;

  function automatic logic [63:0] ent_addr(input int i);
    return {32'(i), 32'(32'hFFF0 + i)};
  endfunction

  function automatic logic [31:0] ent_data(input int i);
    return 32'(32'hCAFE + (i << 16));
  endfunction

  task automatic push_exp(input int v);
    exp_t e;
    e.addr = ent_addr(v);
    e.data = ent_data(v);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (drop) drop_cnt++;
    if (cfg_int) begin
      int_cnt++;
      int_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("int_expected", 64'(exp_q.size()), 64'd1);
      else begin
        mon_e = exp_q.pop_front();
        chk("int_addr", cfg_addr, mon_e.addr);
        chk("int_data", 64'(cfg_data), 64'(mon_e.data));
      end
    end
  end

  // core model: answers two cycles after seeing the int pulse
  initial begin
    int r;
    sent = 1'b0;
    fail = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_int) begin
        r = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
        repeat (2) @(posedge clk);
        #1;
        if (r == 0) sent = 1'b1;
        else if (r == 1) fail = 1'b1;
        if (r != 2) begin
          @(posedge clk);
          #1;
          sent = 1'b0;
          fail = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v;
    tick();
    irq = '0;
  endtask

  task automatic wait_ints(input int target, input int budget);
    int b = 0;
    while (int_cnt < target && b < budget) begin
      tick();
      b++;
    end
    chk("int_count", 64'(int_cnt), 64'(target));
  endtask

  task automatic drain();
    int b = 0;
    while (busy && b < 300) begin
      tick();
      b++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  int base, t0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      mem[4*i]   = 32'(32'hFFF0 + i);
      mem[4*i+1] = 32'(i);
      mem[4*i+2] = ent_data(i);
      mem[4*i+3] = '0;
    end
    rst = 1'b1; irq = '0; msix_enable = 1'b1; msix_func_mask = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_int", 64'(cfg_int), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", cfg_addr, 64'd0);
    chk("rst_data", 64'(cfg_data), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // three vectors in round-robin order, latency and back-to-back spacing
    base = int_cnt;
    push_exp(0); push_exp(2); push_exp(3);
    t0 = cyc;
    pulse_irq(4'b1101);
    wait_ints(base + 3, 200);
    drain();
    if (int_cyc_q.size() >= base + 3) begin
      chk("latency_first", 64'(int_cyc_q[base] - t0), 64'd6);
      chk("gap_after_sent", 64'(int_cyc_q[base+1] - int_cyc_q[base]), 64'd8);
      chk("gap_after_sent2", 64'(int_cyc_q[base+2] - int_cyc_q[base+1]), 64'd8);
    end
    chk("t1_pending", 64'(pending), 64'd0);

    // masked vector stays pending until unmasked
    mem[4*2+3] = 32'd1;
    base = int_cnt;
    pulse_irq(4'b0100);
    tick(200);
    chk("masked_no_int", 64'(int_cnt), 64'(base));
    chk("masked_pending", 64'(pending), 64'b0100);
    push_exp(2);
    mem[4*2+3] = 32'd0;
    wait_ints(base + 1, 100);
    drain();
    chk("unmasked_pending", 64'(pending), 64'd0);

    // fail, fail, sent: three ints, no drop
    base = int_cnt;
    resp_q.push_back(1); resp_q.push_back(1); resp_q.push_back(0);
    push_exp(1); push_exp(1); push_exp(1);
    pulse_irq(4'b0010);
    wait_ints(base + 3, 200);
    drain();
    chk("retry_no_drop", 64'(drop_cnt), 64'd0);

    // fail x3: vector dropped, no fourth attempt
    base = int_cnt;
    resp_q.push_back(1); resp_q.push_back(1); resp_q.push_back(1);
    push_exp(1); push_exp(1); push_exp(1);
    pulse_irq(4'b0010);
    wait_ints(base + 3, 200);
    drain();
    tick(50);
    chk("drop_no_4th", 64'(int_cnt), 64'(base + 3));
    chk("drop_once", 64'(drop_cnt), 64'd1);
    chk("drop_pending", 64'(pending), 64'd0);

    // irq[0] held: vector 1 still gets its turn; release yields one final v0
    base = int_cnt;
    push_exp(0); push_exp(1); push_exp(0); push_exp(0); push_exp(0);
    irq = 4'b0011;
    tick();
    irq = 4'b0001;
    wait_ints(base + 4, 200);
    irq = '0;
    wait_ints(base + 5, 100);
    drain();
    tick(30);
    chk("hold_final_count", 64'(int_cnt), 64'(base + 5));
    chk("hold_pending", 64'(pending), 64'd0);

    // serve vector 3 so the pointer wraps to 0, then gate with enable
    base = int_cnt;
    push_exp(3);
    pulse_irq(4'b1000);
    wait_ints(base + 1, 100);
    drain();
    base = int_cnt;
    msix_enable = 1'b0;
    pulse_irq(4'b0011);
    tick(50);
    chk("disabled_no_int", 64'(int_cnt), 64'(base));
    chk("disabled_pending", 64'(pending), 64'b0011);
    push_exp(0); push_exp(1);
    msix_enable = 1'b1;
    wait_ints(base + 2, 200);
    drain();

    // reset while waiting for the core
    base = int_cnt;
    resp_q.push_back(2);
    push_exp(0);
    pulse_irq(4'b0001);
    wait_ints(base + 1, 100);
    tick(3);
    irq = 4'b0010;
    tick();
    irq = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_pending", 64'(pending), 64'b0010);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("wait_rst_int", 64'(cfg_int), 64'd0);
    chk("wait_rst_pending", 64'(pending), 64'd0);
    chk("wait_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
    base = int_cnt;
    push_exp(0);
    t0 = cyc;
    pulse_irq(4'b0001);
    wait_ints(base + 1, 100);
    drain();
    if (int_cyc_q.size() >= base + 1)
      chk("post_rst_latency", 64'(int_cyc_q[base] - t0), 64'd6);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
